// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU MEM stage and a DMA/debug master.
// Define ARB_RR_EN for round-robin contention instead of CPU priority with MAX_WAIT override.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  input  logic [1:0]  cpu_size,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wd,
  input  logic [1:0]  dma_size,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rd
);

  typedef enum logic {ST_SHARED, ST_DMA_BURST} state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  state_t     state, state_next;
  logic [3:0] burst_cnt, burst_next;
  logic       cpu_gnt, dma_win, contend_dma;

`ifdef ARB_RR_EN
  logic last_dma;
  assign contend_dma = ~last_dma;
`else
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
  logic [3:0] wait_cnt, wait_next;
  assign contend_dma = (wait_cnt == WAIT_LIMIT);
`endif

  always_comb begin
    state_next = state;
    burst_next = burst_cnt;
    cpu_gnt    = 1'b0;
    dma_win    = 1'b0;
    if (!rst) begin
      case (state)
        ST_SHARED: begin
          if (cpu_req && dma_req) begin
            dma_win = contend_dma;
            cpu_gnt = ~contend_dma;
          end else begin
            cpu_gnt = cpu_req;
            dma_win = dma_req;
          end
          if (dma_win && dma_lock) begin
            state_next = ST_DMA_BURST;
            burst_next = 4'd1;
          end
        end
        ST_DMA_BURST: begin
          // Burst holds ownership until the beat limit is reached and the CPU is waiting.
          if (dma_req && !(cpu_req && burst_cnt == BURST_LIMIT))
            dma_win = 1'b1;
          else
            cpu_gnt = cpu_req;
          if (dma_win && dma_lock) begin
            burst_next = (burst_cnt == BURST_LIMIT) ? BURST_LIMIT : burst_cnt + 4'd1;
          end else begin
            state_next = ST_SHARED;
            burst_next = '0;
          end
        end
        default: state_next = ST_SHARED;
      endcase
    end
  end

`ifndef ARB_RR_EN
  always_comb begin
    wait_next = '0;
    if (dma_req && !dma_win)
      wait_next = (wait_cnt == WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt + 4'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SHARED;
      burst_cnt <= '0;
`ifdef ARB_RR_EN
      last_dma  <= 1'b1;
`else
      wait_cnt  <= '0;
`endif
    end else begin
      state     <= state_next;
      burst_cnt <= burst_next;
`ifdef ARB_RR_EN
      if (dma_win)
        last_dma <= 1'b1;
      else if (cpu_gnt)
        last_dma <= 1'b0;
`else
      wait_cnt  <= wait_next;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_win & ~dma_we;
      if (dma_win && !dma_we)
        dma_rdata <= mem_rd;
    end
  end

  assign dma_gnt   = dma_win;
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_rd    = mem_rd;
  assign mem_a     = dma_win ? dma_addr : cpu_addr;
  assign mem_wd    = dma_win ? dma_wd   : cpu_wd;
  assign mem_size  = dma_win ? dma_size : cpu_size;
  assign mem_we    = dma_win ? dma_we   : (cpu_gnt & cpu_we);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed literal checks followed by randomized traffic
// compared every cycle against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

  localparam int unsigned MW = 4;
  localparam int unsigned MB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wd, cpu_rd;
  logic [1:0]  cpu_size;
  logic        cpu_stall;
  logic        dma_req, dma_lock, dma_we;
  logic [31:0] dma_addr, dma_wd, dma_rdata;
  logic [1:0]  dma_size;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
  logic [1:0]  mem_size;

  dmem_arbiter #(.MAX_WAIT(MW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_size(cpu_size), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wd(dma_wd), .dma_size(dma_size), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_size(mem_size), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory: writes on negedge of the grant cycle, combinational read.
  logic [31:0] mem [64];
  always @(negedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  assign mem_rd = mem[mem_a[7:2]];

  // Reference model state
  logic [31:0] mdl_mem [64];
  bit          m_burst, m_last_dma, m_rvalid;
  int unsigned m_wait, m_bcnt;
  logic [31:0] m_rdata;
  bit          cpu_hold, dma_hold;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0 = nobody, 1 = CPU, 2 = DMA
  function automatic int winner();
    if (rst) return 0;
    if (m_burst) begin
      if (dma_req && !(cpu_req && m_bcnt == MB)) return 2;
      return cpu_req ? 1 : 0;
    end
    if (cpu_req && dma_req) begin
`ifdef ARB_RR_EN
      return m_last_dma ? 1 : 2;
`else
      return (m_wait == MW) ? 2 : 1;
`endif
    end
    return cpu_req ? 1 : (dma_req ? 2 : 0);
  endfunction

  task automatic model_reset();
    m_burst = 0; m_wait = 0; m_bcnt = 0; m_last_dma = 1; m_rvalid = 0; m_rdata = '0;
  endtask

  task automatic settle();
    int w;
    logic [31:0] ea;
    #3;
    w  = winner();
    ea = (w == 2) ? dma_addr : cpu_addr;
    chk("cpu_stall", cpu_stall, cpu_req && w != 1);
    chk("dma_gnt", dma_gnt, w == 2);
    chk("mem_we", mem_we, (w == 2) ? dma_we : ((w == 1) ? cpu_we : 1'b0));
    chk("mem_a", mem_a, ea);
    chk("mem_wd", mem_wd, (w == 2) ? dma_wd : cpu_wd);
    chk("mem_size", mem_size, (w == 2) ? dma_size : cpu_size);
    chk("cpu_rd", cpu_rd, mdl_mem[ea[7:2]]);
    chk("dma_rvalid", dma_rvalid, m_rvalid);
    chk("dma_rdata", dma_rdata, m_rdata);
  endtask

  task automatic advance();
    int w;
    w = winner();
    cpu_hold = cpu_req && w != 1;
    dma_hold = dma_req && w != 2;
    if (rst) model_reset();
    else begin
      if (w == 1 && cpu_we) mdl_mem[cpu_addr[7:2]] = cpu_wd;
      if (w == 2 && dma_we) mdl_mem[dma_addr[7:2]] = dma_wd;
      m_rvalid = (w == 2 && !dma_we);
      if (m_rvalid) m_rdata = mdl_mem[dma_addr[7:2]];
      m_wait = (dma_req && w != 2) ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : 0;
      if (w == 2 && dma_lock) begin
        m_bcnt  = m_burst ? ((m_bcnt + 1 > MB) ? MB : m_bcnt + 1) : 1;
        m_burst = 1;
      end else begin
        m_burst = 0;
        m_bcnt  = 0;
      end
      if (w == 1) m_last_dma = 0;
      else if (w == 2) m_last_dma = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set(input logic r, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz);
    cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wd = wd; cpu_size = sz;
  endtask

  task automatic dma_set(input logic r, input logic lk, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz);
    dma_req = r; dma_lock = lk; dma_we = we; dma_addr = a; dma_wd = wd; dma_size = sz;
  endtask

  initial begin
    logic [5:0] pat;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      mdl_mem[i] = mem[i];
    end
    model_reset();
    rst = 1'b1;
    cpu_set(1, 1, 32'h10, 32'h1111_2222, 2'd0);
    dma_set(1, 1, 1, 32'h14, 32'h3333_4444, 2'd0);
    @(posedge clk);
    #1;

    // Reset state
    settle();
    chk("rst_stall", cpu_stall, 1'b1);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_gnt", dma_gnt, 1'b0);
    chk("rst_rvalid", dma_rvalid, 1'b0);
    chk("rst_rdata", dma_rdata, 32'h0);
    advance();
    rst = 1'b0;

    // CPU only write, then readback
    cpu_set(1, 1, 32'h10, 32'hDEAD_BEEF, 2'd0);
    dma_set(0, 0, 0, 32'h0, 32'h0, 2'd0);
    settle();
    chk("t1_stall", cpu_stall, 1'b0);
    chk("t1_we", mem_we, 1'b1);
    advance();
    cpu_set(1, 1, 32'h20, 32'h0000_00A5, 2'd2);
    settle(); advance();
    cpu_set(1, 0, 32'h10, 32'h0, 2'd0);
    settle();
    chk("t1_readback", cpu_rd, 32'hDEAD_BEEF);
    advance();

    // DMA read of 0x20
    cpu_set(0, 0, 32'h0, 32'h0, 2'd0);
    dma_set(1, 0, 0, 32'h20, 32'h0, 2'd2);
    settle();
    chk("t3_gnt", dma_gnt, 1'b1);
    advance();
    dma_set(0, 0, 0, 32'h0, 32'h0, 2'd0);
    settle();
    chk("t3_rvalid", dma_rvalid, 1'b1);
    chk("t3_rdata", dma_rdata, 32'h0000_00A5);
    advance();

    // Continuous contention
`ifdef ARB_RR_EN
    pat = 6'b101010;
`else
    pat = 6'b010000;
`endif
    cpu_set(1, 0, 32'h30, 32'h0, 2'd2);
    dma_set(1, 0, 0, 32'h34, 32'h0, 2'd2);
    for (int i = 0; i < 6; i++) begin
      settle();
      chk($sformatf("contend_stall%0d", i), cpu_stall, pat[i]);
      chk($sformatf("contend_gnt%0d", i), dma_gnt, pat[i]);
      advance();
    end
    cpu_set(0, 0, 32'h0, 32'h0, 2'd0);
    dma_set(0, 0, 0, 32'h0, 32'h0, 2'd0);
    settle(); advance();

    // Locked burst with waiting CPU
    dma_set(1, 1, 1, 32'h80, $urandom, 2'd0);
    settle();
    chk("t4_beat1", dma_gnt, 1'b1);
    advance();
    cpu_set(1, 0, 32'h40, 32'h0, 2'd2);
    for (int b = 1; b < 8; b++) begin
      dma_set(1, 1, 1, 32'h80 + 32'(4 * b), $urandom, 2'd0);
      settle();
      chk($sformatf("t4_beat%0d", b + 1), dma_gnt, 1'b1);
      chk($sformatf("t4_stall%0d", b + 1), cpu_stall, 1'b1);
      advance();
    end
    settle();
    chk("t4_release_gnt", dma_gnt, 1'b0);
    chk("t4_release_stall", cpu_stall, 1'b0);
    advance();
`ifndef ARB_RR_EN
    settle();
    chk("t4_shared_stall", cpu_stall, 1'b0);
    advance();
`endif
    cpu_set(0, 0, 32'h0, 32'h0, 2'd0);
    dma_set(0, 0, 0, 32'h0, 32'h0, 2'd0);
    settle(); advance();

    // Reset during beat 3 of a write burst
    dma_set(1, 1, 1, 32'hC0, $urandom, 2'd0);
    settle(); chk("t5_beat1", dma_gnt, 1'b1); advance();
    dma_set(1, 1, 1, 32'hC4, $urandom, 2'd0);
    settle(); advance();
    rst = 1'b1;
    cpu_set(1, 1, 32'h50, 32'h5555_AAAA, 2'd0);
    dma_set(1, 1, 1, 32'hC8, $urandom, 2'd0);
    settle();
    chk("t5_we", mem_we, 1'b0);
    chk("t5_gnt", dma_gnt, 1'b0);
    chk("t5_stall", cpu_stall, 1'b1);
    advance();
    rst = 1'b0;
    settle();
    chk("t5_cpu_first", cpu_stall, 1'b0);
    chk("t5_dma_loses", dma_gnt, 1'b0);
    advance();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!cpu_hold)
        cpu_set($urandom_range(0, 2) != 0, 1'($urandom), $urandom, $urandom, 2'($urandom));
      if (!dma_hold)
        dma_set($urandom_range(0, 7) != 0, 1'b0, 1'($urandom), $urandom, $urandom, 2'($urandom));
      dma_lock = ($urandom_range(0, 3) != 0);
      settle();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
